// File: rtl/fir_mac.sv
// fir_mac: 32-tap serial FIR multiply-accumulate engine with on-chip coefficient bank.
// Optional build macro FIR_MAC_SAT_EN: saturate y to the 16-bit signed range instead of wrapping.
module fir_mac (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        start,
    output logic [4:0]  adres,
    input  logic [15:0] dane_in,
    input  logic        wsp_we,
    input  logic [4:0]  wsp_adres,
    input  logic [15:0] wsp_dane,
    output logic [15:0] y,
    output logic        y_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned NTAPS = 32;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACCW  = 37;
    localparam int unsigned FRAC  = 15;
`ifdef FIR_MAC_SAT_EN
    localparam int unsigned SW    = ACCW - FRAC;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [AW-1:0]          cnt, cnt_d;
    logic [AW-1:0]          adres_d;
    logic                   busy_d;
    logic                   yv_d;
    logic                   y_load;
    logic                   acc_clr;
    logic                   ovr_set;

    logic signed [DW-1:0]   h [NTAPS];
    logic                   mac_en;
    logic [AW-1:0]          k_q;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic [DW-1:0]          y_c;

    // State and tap counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and next-output decode; RUN walks 32 taps, FLUSH waits out the read/MAC pipeline
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        adres_d = '0;
        busy_d  = 1'b1;
        yv_d    = 1'b0;
        y_load  = 1'b0;
        acc_clr = 1'b0;
        ovr_set = start && (state != IDLE);
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                if (cnt == AW'(NTAPS - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt + AW'(1);
                    adres_d = cnt + AW'(1);
                end
            end
            FLUSH: begin
                if (cnt == AW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    y_load  = 1'b1;
                    yv_d    = 1'b1;
                end else begin
                    cnt_d = cnt + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adres   <= '0;
            busy    <= 1'b0;
            y_valid <= 1'b0;
            y       <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            adres   <= '0;
            busy    <= 1'b0;
            y_valid <= 1'b0;
            y       <= '0;
            overrun <= 1'b0;
        end else begin
            adres   <= adres_d;
            busy    <= busy_d;
            y_valid <= yv_d;
            if (y_load) begin
                y <= y_c;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    // Coefficient bank; writes are locked out while a convolution is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                h[i] <= '0;
            end
        end else if (wsp_we && !busy) begin
            h[wsp_adres] <= wsp_dane;
        end
    end

    // Delay the tap index one cycle to line up with the returned sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en <= 1'b0;
            k_q    <= '0;
        end else if (clr) begin
            mac_en <= 1'b0;
            k_q    <= '0;
        end else begin
            mac_en <= (state == RUN);
            k_q    <= cnt;
        end
    end

    assign prod = PW'($signed(dane_in)) * PW'(h[k_q]);

    // Accumulator; 37 bits holds 32 full-scale products without wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr || acc_clr) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= acc + ACCW'(prod);
        end
    end

`ifdef FIR_MAC_SAT_EN
    logic signed [SW-1:0] acc_sh;
    assign acc_sh = acc[ACCW-1:FRAC];

    // Floor-shifted result clamped to the 16-bit signed range
    always_comb begin
        y_c = acc_sh[DW-1:0];
        if (acc_sh > SW'(32767)) begin
            y_c = 16'h7FFF;
        end else if (acc_sh < -SW'(32768)) begin
            y_c = 16'h8000;
        end
    end
`else
    // Floor-shifted result, low 16 bits kept
    always_comb begin
        y_c = acc[FRAC+DW-1:FRAC];
    end
`endif

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac with a scoreboard of expected y values and their arrival cycles.
module tb_fir_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [4:0]  adres;
    logic [15:0] dane_in;
    logic        wsp_we;
    logic [4:0]  wsp_adres;
    logic [15:0] wsp_dane;
    logic [15:0] y;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    fir_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .adres     (adres),
        .dane_in   (dane_in),
        .wsp_we    (wsp_we),
        .wsp_adres (wsp_adres),
        .wsp_dane  (wsp_dane),
        .y         (y),
        .y_valid   (y_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic signed [15:0] taps [32];
    logic signed [15:0] h_m  [32];
    int                 cyc = 0;
    int                 t0 = 0;
    int                 busy_cnt = 0;
    int                 checks = 0;
    int                 errors = 0;

    // Sample shift register model: data for last cycle's address
    always @(posedge clk) dane_in <= taps[adres];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model();
        longint acc = 0;
        longint sh;
        for (int k = 0; k < 32; k++) begin
            acc += longint'(taps[k]) * longint'(h_m[k]);
        end
        sh = acc >>> 15;
`ifdef FIR_MAC_SAT_EN
        if (sh > 32767) return 16'h7FFF;
        if (sh < -32768) return 16'h8000;
`endif
        return 16'(sh);
    endfunction

    // Monitor: adres sequence, busy length and y_valid against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                check("adres_seq", 32'(adres), (cyc - t0 < 32) ? 32'(cyc - t0) : 32'd0);
            end else begin
                check("adres_idle", 32'(adres), 32'd0);
            end
            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_y_valid", 32'(y_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y_value", 32'(y), 32'(e.y));
                    check("y_valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic write_coef(input int k, input logic [15:0] v);
        wsp_we    = 1'b1;
        wsp_adres = 5'(k);
        wsp_dane  = v;
        h_m[k]    = v;
        @(negedge clk);
        wsp_we    = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int k = 0; k < 32; k++) write_coef(k, v);
    endtask

    task automatic set_taps(input logic [15:0] v);
        for (int k = 0; k < 32; k++) taps[k] = v;
    endtask

    // Pulse start; returns at the negedge after the accepting edge
    task automatic launch(input bit push, input logic [15:0] ey);
        start    = 1'b1;
        t0       = cyc + 1;
        busy_cnt = 0;
        if (push) exp_q.push_back('{y: ey, cyc: cyc + 35});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_y_valid"}, 32'(y_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_adres"}, 32'(adres), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; start = 1'b0;
        wsp_we = 1'b0; wsp_adres = '0; wsp_dane = '0;
        for (int k = 0; k < 32; k++) begin
            taps[k] = '0;
            h_m[k]  = '0;
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse response through h[0]
        write_coef(0, 16'h7FFF);
        taps[0] = 16'sd1000;
        launch(1'b1, 16'd999);
        wait_idle("impulse");
        check("impulse_busy_len", 32'(busy_cnt), 32'd35);
        check("impulse_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        check("y_hold", 32'(y), 32'd999);

        // Flat filter
        load_all(16'h4000);
        set_taps(16'd1000);
        launch(1'b1, 16'h3E80);
        wait_idle("flat");
        check("flat_busy_len", 32'(busy_cnt), 32'd35);
        check("flat_drained", 32'(exp_q.size()), 32'd0);

        // Positive overflow
        load_all(16'h7FFF);
        set_taps(16'h7FFF);
`ifdef FIR_MAC_SAT_EN
        launch(1'b1, 16'h7FFF);
`else
        launch(1'b1, 16'hFFC0);
`endif
        wait_idle("ovf_pos");

        // Negative overflow
        set_taps(16'h8000);
`ifdef FIR_MAC_SAT_EN
        launch(1'b1, 16'h8000);
`else
        launch(1'b1, 16'h0020);
`endif
        wait_idle("ovf_neg");
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Start and coefficient write on the same idle edge
        load_all(16'h0100);
        for (int k = 0; k < 32; k++) taps[k] = 16'(k * 37 - 500);
        wsp_we = 1'b1; wsp_adres = 5'd3; wsp_dane = 16'h1000;
        h_m[3] = 16'h1000;
        launch(1'b1, model());
        wsp_we = 1'b0;
        wait_idle("same_edge");
        check("same_edge_drained", 32'(exp_q.size()), 32'd0);

        // Collision: write at T0+5 ignored, second start at T0+10 flags overrun
        load_all(16'h4000);
        set_taps(16'd1000);
        launch(1'b1, 16'h3E80);
        repeat (4) @(negedge clk);
        wsp_we = 1'b1; wsp_adres = 5'd0; wsp_dane = 16'h1234;
        @(negedge clk);
        wsp_we = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("collision_overrun", 32'(overrun), 32'd1);
        wait_idle("collision");
        repeat (40) @(negedge clk);
        check("collision_single_y", 32'(exp_q.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        launch(1'b1, 16'h3E80);
        wait_idle("h_unchanged");

        // Soft clear mid-run keeps coefficients
        launch(1'b0, 16'h0000);
        repeat (14) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all_zero("clr_abort");
        repeat (40) @(negedge clk);
        launch(1'b1, 16'h3E80);
        wait_idle("after_clr");
        check("after_clr_drained", 32'(exp_q.size()), 32'd0);

        // Async reset mid-run wipes coefficients
        launch(1'b0, 16'h0000);
        repeat (14) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_abort");
        for (int k = 0; k < 32; k++) h_m[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        launch(1'b1, model());
        wait_idle("after_rst");
        check("after_rst_y_zero", 32'(y), 32'd0);
        repeat (3) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac.md
FIR_MAC -- requirements
Module: fir_mac

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port clr, input, 1 bit: synchronous soft clear of the datapath; coefficients are kept.
REQ-004 SHALL have port start, input, 1 bit: pulse meaning a new sample was just shifted into the tap register.
REQ-005 SHALL have port adres, output, 5 bits: tap read address driven to the sample shift register.
REQ-006 SHALL have port dane_in, input, 16 bits: signed tap sample returned for the adres of the previous cycle.
REQ-007 SHALL have port wsp_we, input, 1 bit: coefficient write enable.
REQ-008 SHALL have port wsp_adres, input, 5 bits: coefficient write index 0..31.
REQ-009 SHALL have port wsp_dane, input, 16 bits: signed Q1.15 coefficient value.
REQ-010 SHALL have port y, output, 16 bits: signed filtered output sample.
REQ-011 SHALL have port y_valid, output, 1 bit: one-cycle strobe marking a new y.
REQ-012 SHALL have port busy, output, 1 bit: high while a convolution is in progress.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag set when start arrives while busy.

Function
REQ-014 SHALL hold 32 coefficients h[0..31] in internal registers, written on a clock edge with wsp_we=1 and busy=0.
REQ-015 SHALL ignore wsp_we while busy=1, leaving coefficients unchanged.
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-017 In IDLE, start=1 on edge T0 SHALL clear the accumulator, enter RUN and set busy=1.
REQ-018 RUN SHALL drive adres=k on cycle T0+1+k for k=0..31, then enter FLUSH.
REQ-019 On edges T0+2..T0+33 SHALL add dane_in*h[k] to the accumulator, where k is the adres issued one cycle earlier; FLUSH covers the last product.
REQ-020 Products SHALL be signed 16x16 to 32 bits; the accumulator SHALL be signed 37 bits and SHALL never wrap.
REQ-021 DONE SHALL compute y from the accumulator arithmetically shifted right 15 (floor), register it and pulse y_valid=1 for exactly one cycle, 34 cycles after T0.
REQ-022 On the cycle after the y_valid pulse, the FSM SHALL return to IDLE and busy SHALL drop to 0.
REQ-023 start while busy=1 (RUN, FLUSH or DONE) SHALL be ignored and SHALL set overrun=1.
REQ-024 adres SHALL be 0 whenever the FSM is not in RUN.
REQ-025 y SHALL hold its last value between y_valid strobes.
REQ-026 A start and a wsp_we on the same edge in IDLE SHALL both take effect; the write uses pre-edge coefficients for nothing, since the first product uses h[0] at T0+2.

Reset
REQ-027 rst_n=0 SHALL immediately force the FSM to IDLE, with adres=0, y=0, y_valid=0, busy=0, overrun=0, accumulator=0 and all h[k]=0.
REQ-028 clr=1 on an edge SHALL force IDLE, set accumulator, y, y_valid, busy and overrun to 0, suppress any pending y_valid and keep the coefficients; clr SHALL take priority over start.

Configuration
REQ-029 Macro FIR_MAC_SAT_EN defined: the shifted result SHALL saturate to 0x7FFF / 0x8000 when outside the 16-bit signed range.
REQ-030 Macro FIR_MAC_SAT_EN undefined: y SHALL be the low 16 bits of the shifted result (wrap).

Verification
REQ-031 Impulse: h[0]=0x7FFF, all other h=0; tap0=1000, other taps 0; start -> y=999, y_valid exactly 34 cycles after start.
REQ-032 Flat: all h=0x4000, all taps 1000 -> y=16000 (0x3E80), busy high for 35 cycles.
REQ-033 Overflow: all h=0x7FFF, all taps 0x7FFF -> y=0x7FFF with FIR_MAC_SAT_EN defined, y=0xFFC0 without it.
REQ-034 Negative: all h=0x7FFF, all taps 0x8000 -> y=0x8000 with FIR_MAC_SAT_EN defined.
REQ-035 Collision: start again at T0+10 -> overrun=1, only one y_valid; a wsp_we at T0+5 leaves h unchanged.
REQ-036 Abort: rst_n=0 at T0+15 -> every output 0 at once, no y_valid, all h=0; clr at T0+15 instead keeps h and the next start gives the correct y.
